// File: rtl/bf_pkg.sv
// Shared types and constants for the bound flasher: state encoding, lamp count,
// phase target table and kickback points.
package bf_pkg;

    localparam int LAMP_CNT = 16;
    localparam int LVL_W    = 5;
    localparam int IDX_W    = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_UP   = 2'd1,
        ST_DOWN = 2'd2
    } bf_state_e;

    localparam logic [IDX_W-1:0] LAST_PHASE   = 3'd5;
    localparam logic [IDX_W-1:0] KICK_IDX_LO  = 3'd2;
    localparam logic [IDX_W-1:0] KICK_IDX_HI  = 3'd4;
    localparam logic [IDX_W-1:0] KICK_BACK_LO = 3'd1;
    localparam logic [IDX_W-1:0] KICK_BACK_HI = 3'd3;
    localparam logic [LVL_W-1:0] KICK_LVL_LO  = 5'd6;
    localparam logic [LVL_W-1:0] KICK_LVL_HI  = 5'd11;
    localparam logic [LVL_W-1:0] LVL_ONE      = 5'd1;

    // Level at which each phase ends; even phases ramp up, odd phases ramp down.
    function automatic logic [LVL_W-1:0] phase_target(input logic [IDX_W-1:0] idx);
        logic [LVL_W-1:0] tgt;
        case (idx)
            3'd0:    tgt = 5'd6;
            3'd1:    tgt = 5'd0;
            3'd2:    tgt = 5'd11;
            3'd3:    tgt = 5'd6;
            3'd4:    tgt = 5'd16;
            default: tgt = 5'd0;
        endcase
        return tgt;
    endfunction

    // Thermometer code: the lowest lvl lamps are lit.
    function automatic logic [LAMP_CNT-1:0] led_decode(input logic [LVL_W-1:0] lvl);
        logic [LAMP_CNT-1:0] bar;
        for (int k = 0; k < LAMP_CNT; k++) begin
            bar[k] = (k < int'(lvl));
        end
        return bar;
    endfunction

endpackage

// File: rtl/bf_flick_catch.sv
// Flick request capture: set asynchronously by a flick rising edge, dropped on every
// clock edge once sampled. A set that coincides with the clock edge wins.
module bf_flick_catch (
    input  logic clk,
    input  logic reset,
    input  logic flick,
    output logic pending
);

    always_ff @(posedge clk or posedge flick or posedge reset) begin
        if (reset) begin
            pending <= 1'b0;
        end else if (flick) begin
            pending <= 1'b1;
        end else begin
            pending <= 1'b0;
        end
    end

endmodule

// File: rtl/bound_flasher.sv
// 16-lamp bound flasher: ramp sequencer with kickback at lamps 5/10.
// Optional BF_PULSE_FLICK_EN exposes the captured flick request on pulse_flick.
module bound_flasher
    import bf_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                flick,
    output logic [LAMP_CNT-1:0] LED,
    output logic [1:0]          current_state,
    output logic [2:0]          current_index
`ifdef BF_PULSE_FLICK_EN
    ,
    output logic                pulse_flick
`endif
);

    bf_state_e        state;
    logic [IDX_W-1:0] index;
    logic [LVL_W-1:0] level;
    logic             pending;
    logic [LVL_W-1:0] target;
    logic [LVL_W-1:0] lvl_inc;
    logic [LVL_W-1:0] lvl_dec;
    logic             kick_lo;
    logic             kick_hi;

    bf_flick_catch u_catch (
        .clk     (clk),
        .reset   (reset),
        .flick   (flick),
        .pending (pending)
    );

    assign target  = phase_target(index);
    assign lvl_inc = level + LVL_ONE;
    assign lvl_dec = level - LVL_ONE;

    // Kickback only fires at the exact level where the rewound phase would resume.
    assign kick_lo = pending && (index == KICK_IDX_LO) && (level == KICK_LVL_LO);
    assign kick_hi = pending && (index == KICK_IDX_HI) && (level == KICK_LVL_HI);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            index <= '0;
            level <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pending) begin
                        state <= ST_UP;
                        index <= '0;
                    end
                end
                ST_UP: begin
                    if (kick_lo) begin
                        state <= ST_DOWN;
                        index <= KICK_BACK_LO;
                        level <= lvl_dec;
                    end else if (kick_hi) begin
                        state <= ST_DOWN;
                        index <= KICK_BACK_HI;
                        level <= lvl_dec;
                    end else begin
                        level <= lvl_inc;
                        if (lvl_inc == target) begin
                            index <= index + 3'd1;
                            state <= ST_DOWN;
                        end
                    end
                end
                ST_DOWN: begin
                    level <= lvl_dec;
                    if (lvl_dec == target) begin
                        if (index == LAST_PHASE) begin
                            state <= ST_IDLE;
                            index <= '0;
                        end else begin
                            index <= index + 3'd1;
                            state <= ST_UP;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    index <= '0;
                    level <= '0;
                end
            endcase
        end
    end

    assign LED           = led_decode(level);
    assign current_state = state;
    assign current_index = index;

`ifdef BF_PULSE_FLICK_EN
    assign pulse_flick = pending;
`endif

endmodule

// File: tb/tb_bound_flasher.sv
// Randomized scoreboard bench for bound_flasher against a trajectory-table reference model.
module tb_bound_flasher;

    logic        clk;
    logic        reset;
    logic        flick;
    logic [15:0] LED;
    logic [1:0]  current_state;
    logic [2:0]  current_index;
`ifdef BF_PULSE_FLICK_EN
    logic        pulse_flick;
`endif

    bound_flasher dut (
        .clk           (clk),
        .reset         (reset),
        .flick         (flick),
        .LED           (LED),
        .current_state (current_state),
        .current_index (current_index)
`ifdef BF_PULSE_FLICK_EN
        ,
        .pulse_flick   (pulse_flick)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0] lvl;
        logic [1:0] st;
        logic [2:0] idx;
    } snap_t;

    int    vectors    = 0;
    int    miscompares = 0;
    snap_t exp_q[$];
    snap_t traj[$];
    int    pos = -1;
    int    tgt[6] = '{6, 0, 11, 6, 16, 0};

    task automatic check_vec(input string name, input snap_t e);
        logic [15:0] e_led;
        e_led = 16'((32'd1 << e.lvl) - 32'd1);
        vectors++;
        if (LED !== e_led || current_state !== e.st || current_index !== e.idx) begin
            miscompares++;
            $display("FAIL %s @%0t: got LED=%h state=%0d index=%0d, expected LED=%h state=%0d index=%0d",
                     name, $time, LED, current_state, current_index, e_led, e.st, e.idx);
        end
    endtask

    // Whole no-kickback run as a list of post-edge snapshots; entry 0 follows the start edge.
    function automatic void build_traj();
        int lvl = 0;
        bit up;
        traj.push_back('{5'd0, 2'd1, 3'd0});
        for (int p = 0; p < 6; p++) begin
            up = (p % 2 == 0);
            while (lvl != tgt[p]) begin
                lvl = up ? lvl + 1 : lvl - 1;
                if (lvl == tgt[p]) begin
                    if (p == 5) traj.push_back('{5'd0, 2'd0, 3'd0});
                    else        traj.push_back('{5'(lvl), up ? 2'd2 : 2'd1, 3'(p + 1)});
                end else begin
                    traj.push_back('{5'(lvl), up ? 2'd1 : 2'd2, 3'(p)});
                end
            end
        end
    endfunction

    function automatic int find_pos(input snap_t s);
        for (int i = 0; i < traj.size(); i++)
            if (traj[i] == s) return i;
        return -1;
    endfunction

    function automatic snap_t model_out();
        if (pos < 0) return '0;
        return traj[pos];
    endfunction

    function automatic void model_step(input bit pend);
        snap_t cur;
        if (pos < 0) begin
            if (pend) pos = 0;
            return;
        end
        cur = traj[pos];
        if (pend && cur.idx == 3'd2 && cur.lvl == 5'd6)
            pos = find_pos('{5'd5, 2'd2, 3'd1});
        else if (pend && cur.idx == 3'd4 && cur.lvl == 5'd11)
            pos = find_pos('{5'd10, 2'd2, 3'd3});
        else begin
            pos++;
            if (pos >= traj.size() - 1) pos = -1;
        end
    endfunction

    function automatic bit at_kick_point();
        if (pos < 0) return 1'b0;
        return (traj[pos].idx == 3'd2 && traj[pos].lvl == 5'd6) ||
               (traj[pos].idx == 3'd4 && traj[pos].lvl == 5'd11);
    endfunction

    initial begin : monitor
        snap_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_vec("step", e);
            end
        end
    end

    initial begin : driver
        bit pulse;
        bit rst_done;
        int mode;
        snap_t cur;
        reset    = 1'b1;
        flick    = 1'b0;
        rst_done = 1'b0;
        build_traj();

        // A flick during reset must be discarded.
        repeat (2) @(negedge clk);
        #1 flick = 1'b1;
        #2 flick = 1'b0;
        #1 check_vec("reset_hold", '0);
        @(negedge clk);
        #1 check_vec("reset_hold2", '0);
        @(negedge clk);
        #1 reset = 1'b0;
        pos = -1;
        exp_q.push_back('0);

        for (int it = 0; it < 900; it++) begin
            @(negedge clk);
            #1;
            if (reset) begin
                reset = 1'b0;
                #1;
            end
            mode = (it / 150) % 3;
            cur  = model_out();
            if (mode == 0 && !rst_done && pos >= 0 && cur.idx == 3'd4 && cur.lvl == 5'd13) begin
                reset = 1'b1;
                #1 check_vec("async_reset", '0);
                rst_done = 1'b1;
                pos = -1;
                exp_q.push_back('0);
                continue;
            end
            case (mode)
                0:       pulse = (pos < 0);
                1:       pulse = ($urandom_range(0, 5) == 0);
                default: pulse = at_kick_point() ? ($urandom_range(0, 3) != 0) :
                                 (pos < 0)       ? ($urandom_range(0, 1) == 0) :
                                                   ($urandom_range(0, 29) == 0);
            endcase
            if (pulse) begin
                flick = 1'b1;
                #2 flick = 1'b0;
            end
            model_step(pulse);
            exp_q.push_back(model_out());
        end

        @(negedge clk);
        #1;
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
